// File: rtl/load_store_unit_if.sv
// Request, memory and response signals of the load/store unit, bundled with
// the unit's view (slave) and the surrounding pipeline/memory view (master).
interface load_store_unit_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_W-1:0]     req_addr;
  logic [DATA_W-1:0]     req_wdata;

  logic                  mem_valid;
  logic                  mem_ready;
  logic                  mem_we;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_be;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_W-1:0]     mem_rdata;

  logic                  rsp_valid;
  logic [DATA_W-1:0]     rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output mem_ready, mem_rvalid, mem_rdata,
    input  req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    input  rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  mem_ready, mem_rvalid, mem_rdata,
    output req_ready, mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
    output rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit between execute and data memory: byte-enable and lane
// replication for stores, shift/extend for loads, misalignment reporting.
module load_store_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input logic              clock,
  input logic              reset,
  load_store_unit_if.slave bus
);

  localparam int unsigned NB    = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(NB);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} stateT;

  stateT             state;
  logic              memValid;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [NB-1:0]     memBe;
  logic [DATA_W-1:0] memWdata;
  logic              rspValid;
  logic [DATA_W-1:0] rspData;
  logic              rspErr;
  logic [1:0]        sizeQ;
  logic              unsQ;
  logic [OFF_W-1:0]  offQ;

  logic              reqIllegal;
  logic [NB-1:0]     reqBe;
  logic [DATA_W-1:0] reqWdata;
  logic [OFF_W-1:0]  reqOff;
  logic [DATA_W-1:0] rdShifted;
  logic [63:0]       rdWide;
  logic [63:0]       rdExt;
  logic [DATA_W-1:0] loadData;

  assign reqOff = bus.req_addr[OFF_W-1:0];

  // Request decode: alignment check, byte enables and store-lane replication
  always_comb begin
    reqIllegal = 1'b0;
    reqBe      = '0;
    reqWdata   = bus.req_wdata;
    case (bus.req_size)
      2'b00: begin
        reqBe    = NB'(8'h01) << reqOff;
        reqWdata = {NB{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        reqIllegal = bus.req_addr[0];
        reqBe      = NB'(8'h03) << reqOff;
        reqWdata   = {(NB/2){bus.req_wdata[15:0]}};
      end
      2'b10: begin
        reqIllegal = |bus.req_addr[1:0];
        reqBe      = NB'(8'h0F) << reqOff;
        reqWdata   = {(NB/4){bus.req_wdata[31:0]}};
      end
      default: begin
        reqIllegal = (DATA_W == 32) || (|bus.req_addr[2:0]);
        reqBe      = NB'(8'hFF);
        reqWdata   = bus.req_wdata;
      end
    endcase
  end

  // Load path: move the addressed lane to bit 0, then extend from its top bit
  assign rdShifted = bus.mem_rdata >> {offQ, 3'b000};

  always_comb begin
    rdWide = 64'(rdShifted);
    rdExt  = rdWide;
    case (sizeQ)
      2'b00:   rdExt = {{56{~unsQ & rdWide[7]}},  rdWide[7:0]};
      2'b01:   rdExt = {{48{~unsQ & rdWide[15]}}, rdWide[15:0]};
      2'b10:   rdExt = {{32{~unsQ & rdWide[31]}}, rdWide[31:0]};
      default: rdExt = rdWide;
    endcase
    loadData = DATA_W'(rdExt);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      memValid <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= '0;
      memBe    <= '0;
      memWdata <= '0;
      rspValid <= 1'b0;
      rspData  <= '0;
      rspErr   <= 1'b0;
      sizeQ    <= 2'b00;
      unsQ     <= 1'b0;
      offQ     <= '0;
    end else begin
      rspValid <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            sizeQ   <= bus.req_size;
            unsQ    <= bus.req_unsigned;
            offQ    <= reqOff;
            rspData <= '0;
            rspErr  <= reqIllegal;
            if (reqIllegal) begin
              state    <= RESP;
              rspValid <= 1'b1;
            end else begin
              state    <= ISSUE;
              memValid <= 1'b1;
              memWe    <= bus.req_we;
              memAddr  <= {bus.req_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
              memBe    <= reqBe;
              memWdata <= reqWdata;
            end
          end
        end
        ISSUE: begin
          if (bus.mem_ready) begin
            memValid <= 1'b0;
            if (memWe) begin
              state    <= RESP;
              rspValid <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (bus.mem_rvalid) begin
            rspData  <= loadData;
            state    <= RESP;
            rspValid <= 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state == IDLE) && !reset;
  assign bus.mem_valid = memValid;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_be    = memBe;
  assign bus.mem_wdata = memWdata;
  assign bus.rsp_valid = rspValid;
  assign bus.rsp_data  = rspData;
  assign bus.rsp_err   = rspErr;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: 32-bit and 64-bit instances side by side.
module tb_load_store_unit;

  logic clock;
  logic reset;
  int   tests;
  int   fails;

  load_store_unit_if #(.DATA_W(32), .ADDR_W(32)) busA ();
  load_store_unit_if #(.DATA_W(64), .ADDR_W(32)) busB ();

  load_store_unit #(.DATA_W(32), .ADDR_W(32)) dutA (.clock(clock), .reset(reset), .bus(busA));
  load_store_unit #(.DATA_W(64), .ADDR_W(32)) dutB (.clock(clock), .reset(reset), .bus(busB));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic reqA(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    busA.req_valid    = 1'b1;
    busA.req_we       = we;
    busA.req_size     = size;
    busA.req_unsigned = uns;
    busA.req_addr     = addr;
    busA.req_wdata    = wdata;
  endtask

  task automatic reqB(input logic we, input logic [1:0] size, input logic uns,
                      input logic [31:0] addr, input logic [63:0] wdata);
    busB.req_valid    = 1'b1;
    busB.req_we       = we;
    busB.req_size     = size;
    busB.req_unsigned = uns;
    busB.req_addr     = addr;
    busB.req_wdata    = wdata;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1;
    busA.req_valid = 1'b0; busA.req_we = 1'b0; busA.req_size = 2'b00;
    busA.req_unsigned = 1'b0; busA.req_addr = '0; busA.req_wdata = '0;
    busA.mem_ready = 1'b1; busA.mem_rvalid = 1'b0; busA.mem_rdata = '0;
    busB.req_valid = 1'b0; busB.req_we = 1'b0; busB.req_size = 2'b00;
    busB.req_unsigned = 1'b0; busB.req_addr = '0; busB.req_wdata = '0;
    busB.mem_ready = 1'b1; busB.mem_rvalid = 1'b0; busB.mem_rdata = '0;

    // Reset values
    step();
    check("rst_req_ready", 64'(busA.req_ready), 64'd0);
    check("rst_mem_valid", 64'(busA.mem_valid), 64'd0);
    check("rst_mem_we",    64'(busA.mem_we),    64'd0);
    check("rst_mem_be",    64'(busA.mem_be),    64'd0);
    check("rst_mem_addr",  64'(busA.mem_addr),  64'd0);
    check("rst_mem_wdata", 64'(busA.mem_wdata), 64'd0);
    check("rst_rsp_valid", 64'(busA.rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(busA.rsp_data),  64'd0);
    check("rst_rsp_err",   64'(busA.rsp_err),   64'd0);
    reset = 1'b0;
    step();
    check("post_rst_ready", 64'(busA.req_ready), 64'd1);

    // Signed byte load at 0x1003
    reqA(1'b0, 2'b00, 1'b0, 32'h1003, 32'h0);
    step();
    busA.req_valid = 1'b0;
    check("lbs_mem_valid", 64'(busA.mem_valid), 64'd1);
    check("lbs_mem_be",    64'(busA.mem_be),    64'h8);
    check("lbs_mem_addr",  64'(busA.mem_addr),  64'h1000);
    check("lbs_mem_we",    64'(busA.mem_we),    64'd0);
    check("lbs_req_ready", 64'(busA.req_ready), 64'd0);
    step();
    check("lbs_wait_valid", 64'(busA.mem_valid), 64'd0);
    busA.mem_rdata = 32'h80FF_1234;
    busA.mem_rvalid = 1'b1;
    step();
    busA.mem_rvalid = 1'b0;
    check("lbs_rsp_valid", 64'(busA.rsp_valid), 64'd1);
    check("lbs_rsp_data",  64'(busA.rsp_data),  64'hFFFF_FF80);
    check("lbs_rsp_err",   64'(busA.rsp_err),   64'd0);
    step();
    check("lbs_rsp_pulse", 64'(busA.rsp_valid), 64'd0);
    check("lbs_ready",     64'(busA.req_ready), 64'd1);

    // Unsigned byte load at 0x1003
    reqA(1'b0, 2'b00, 1'b1, 32'h1003, 32'h0);
    step();
    busA.req_valid = 1'b0;
    step();
    busA.mem_rvalid = 1'b1;
    step();
    busA.mem_rvalid = 1'b0;
    check("lbu_rsp_valid", 64'(busA.rsp_valid), 64'd1);
    check("lbu_rsp_data",  64'(busA.rsp_data),  64'h0000_0080);
    step();

    // Half store at 0x2002
    reqA(1'b1, 2'b01, 1'b0, 32'h2002, 32'h0000_ABCD);
    step();
    busA.req_valid = 1'b0;
    check("sh_mem_addr",  64'(busA.mem_addr),  64'h2000);
    check("sh_mem_be",    64'(busA.mem_be),    64'hC);
    check("sh_mem_wdata", 64'(busA.mem_wdata), 64'hABCD_ABCD);
    check("sh_mem_we",    64'(busA.mem_we),    64'd1);
    check("sh_early_rsp", 64'(busA.rsp_valid), 64'd0);
    step();
    check("sh_rsp_valid", 64'(busA.rsp_valid), 64'd1);
    check("sh_rsp_data",  64'(busA.rsp_data),  64'd0);
    check("sh_rsp_err",   64'(busA.rsp_err),   64'd0);
    step();
    check("sh_rsp_pulse", 64'(busA.rsp_valid), 64'd0);

    // Misaligned word load
    reqA(1'b0, 2'b10, 1'b0, 32'h1002, 32'h0);
    step();
    busA.req_valid = 1'b0;
    check("mis_rsp_valid", 64'(busA.rsp_valid), 64'd1);
    check("mis_rsp_err",   64'(busA.rsp_err),   64'd1);
    check("mis_rsp_data",  64'(busA.rsp_data),  64'd0);
    check("mis_mem_valid", 64'(busA.mem_valid), 64'd0);
    step();
    check("mis_mem_valid2", 64'(busA.mem_valid), 64'd0);
    check("mis_rsp_pulse",  64'(busA.rsp_valid), 64'd0);

    // Double access on a 32-bit unit; a request offered during RESP waits a cycle
    reqA(1'b0, 2'b11, 1'b0, 32'h1000, 32'h0);
    step();
    check("dbl_rsp_valid", 64'(busA.rsp_valid), 64'd1);
    check("dbl_rsp_err",   64'(busA.rsp_err),   64'd1);
    check("dbl_mem_valid", 64'(busA.mem_valid), 64'd0);
    check("dbl_ready_resp", 64'(busA.req_ready), 64'd0);
    reqA(1'b0, 2'b01, 1'b0, 32'h1001, 32'h0);
    step();
    check("resp_no_accept", 64'(busA.rsp_valid), 64'd0);
    check("resp_idle_ready", 64'(busA.req_ready), 64'd1);
    step();
    busA.req_valid = 1'b0;
    check("late_accept_valid", 64'(busA.rsp_valid), 64'd1);
    check("late_accept_err",   64'(busA.rsp_err),   64'd1);
    step();

    // Backpressure: store with mem_ready low for three edges
    busA.mem_ready = 1'b0;
    reqA(1'b1, 2'b10, 1'b0, 32'h3004, 32'h1234_5678);
    step();
    busA.req_valid = 1'b0;
    check("bp_mem_valid", 64'(busA.mem_valid), 64'd1);
    check("bp_mem_wdata", 64'(busA.mem_wdata), 64'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_stall_valid", 64'(busA.mem_valid), 64'd1);
      check("bp_stall_addr",  64'(busA.mem_addr),  64'h3004);
      check("bp_stall_be",    64'(busA.mem_be),    64'hF);
      check("bp_stall_ready", 64'(busA.req_ready), 64'd0);
      check("bp_stall_rsp",   64'(busA.rsp_valid), 64'd0);
    end
    busA.mem_ready = 1'b1;
    step();
    check("bp_rsp_valid", 64'(busA.rsp_valid), 64'd1);
    check("bp_mem_drop",  64'(busA.mem_valid), 64'd0);
    step();

    // Reset while in WAIT, then a stray rvalid after release
    reqA(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
    step();
    busA.req_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check("rw_mem_valid", 64'(busA.mem_valid), 64'd0);
    check("rw_req_ready", 64'(busA.req_ready), 64'd0);
    step();
    reset = 1'b0;
    busA.mem_rdata = 32'hDEAD_BEEF;
    busA.mem_rvalid = 1'b1;
    step();
    busA.mem_rvalid = 1'b0;
    check("rw_no_rsp",    64'(busA.rsp_valid), 64'd0);
    check("rw_ready",     64'(busA.req_ready), 64'd1);
    reqA(1'b0, 2'b10, 1'b0, 32'h4000, 32'h0);
    step();
    busA.req_valid = 1'b0;
    step();
    busA.mem_rdata = 32'h89AB_CDEF;
    busA.mem_rvalid = 1'b1;
    step();
    busA.mem_rvalid = 1'b0;
    check("rw_after_valid", 64'(busA.rsp_valid), 64'd1);
    check("rw_after_data",  64'(busA.rsp_data),  64'h89AB_CDEF);
    step();

    // 64-bit: signed word load at 0x0104
    reqB(1'b0, 2'b10, 1'b0, 32'h0104, 64'h0);
    step();
    busB.req_valid = 1'b0;
    check("w64_mem_be",   64'(busB.mem_be),   64'hF0);
    check("w64_mem_addr", 64'(busB.mem_addr), 64'h0100);
    step();
    busB.mem_rdata = 64'h8765_4321_0000_0000;
    busB.mem_rvalid = 1'b1;
    step();
    busB.mem_rvalid = 1'b0;
    check("w64_rsp_valid", 64'(busB.rsp_valid), 64'd1);
    check("w64_rsp_data",  busB.rsp_data,       64'hFFFF_FFFF_8765_4321);
    step();

    // 64-bit: double load is full width, no extension
    reqB(1'b0, 2'b11, 1'b0, 32'h0108, 64'h0);
    step();
    busB.req_valid = 1'b0;
    check("d64_mem_be", 64'(busB.mem_be), 64'hFF);
    step();
    busB.mem_rdata = 64'hF000_0000_0000_0001;
    busB.mem_rvalid = 1'b1;
    step();
    busB.mem_rvalid = 1'b0;
    check("d64_rsp_data", busB.rsp_data, 64'hF000_0000_0000_0001);
    step();

    // 64-bit: byte store replication and misaligned double
    reqB(1'b1, 2'b00, 1'b0, 32'h0105, 64'h5A);
    step();
    busB.req_valid = 1'b0;
    check("sb64_mem_be",    64'(busB.mem_be), 64'h20);
    check("sb64_mem_wdata", busB.mem_wdata,   64'h5A5A_5A5A_5A5A_5A5A);
    step();
    check("sb64_rsp_valid", 64'(busB.rsp_valid), 64'd1);
    step();
    reqB(1'b0, 2'b11, 1'b0, 32'h0104, 64'h0);
    step();
    busB.req_valid = 1'b0;
    check("md64_rsp_err",   64'(busB.rsp_err),   64'd1);
    check("md64_mem_valid", 64'(busB.mem_valid), 64'd0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Parametrised load/store unit placed between the processor's execute stage and `data_memory`. It generalises the existing byte/half/word load shifter: it also handles stores (byte-enable generation and write-lane replication) and adds a 64-bit data option. It replaces the single-cycle combinational memory path with a request/response handshake, so the memory may take any number of cycles. Misaligned accesses are detected and reported rather than silently truncated.

## Interface
- `DATA_W`, 32. Memory data width; legal values are 32 or 64. `NB` = `DATA_W`/8 byte lanes.
- `ADDR_W`, 32. Byte address width.

Ports:
- `clock`  in  1. Single clock; all state updates on its rising edge.
- `reset`  in  1. Asynchronous, active-high reset.
- `req_valid`  in  1. Execute stage offers an access.
- `req_ready`  out  1. Unit can accept an access this cycle.
- `req_we`  in  1. 1 = store, 0 = load.
- `req_size`  in  2. 00 byte, 01 half, 10 word, 11 double.
- `req_unsigned`  in  1. Loads zero-extend when 1, sign-extend when 0.
- `req_addr`  in  `ADDR_W`. Byte address.
- `req_wdata`  in  `DATA_W`. Store data, right-justified.
- `mem_valid`  out  1. Memory request pending.
- `mem_ready`  in  1. Memory accepts the request.
- `mem_we`  out  1. Write strobe.
- `mem_addr`  out  `ADDR_W`. `req_addr` with the low log2(`NB`) bits cleared.
- `mem_be`  out  `NB`. Byte enables.
- `mem_wdata`  out  `DATA_W`. Lane-replicated store data.
- `mem_rvalid`  in  1. Read data valid.
- `mem_rdata`  in  `DATA_W`. Read data.
- `rsp_valid`  out  1. One-cycle completion pulse.
- `rsp_data`  out  `DATA_W`. Extended load data; 0 for stores and errors.
- `rsp_err`  out  1. Misaligned or illegal size; qualified by `rsp_valid`.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. At most one transaction is in flight.
- `req_ready` = (state == IDLE) && !`reset`.
- IDLE: when `req_valid` && `req_ready`, capture all `req_*` inputs.
  - Illegal accesses go to RESP with err = 1. An access is illegal if `addr` mod bytes(size) != 0, or if size = 11 with `DATA_W` = 32.
  - All other accesses go to ISSUE.
- ISSUE: `mem_valid` = 1 and all `mem_*` outputs are held stable until `mem_ready`.
  - On `mem_ready`, a store goes to RESP.
  - On `mem_ready`, a load goes to WAIT.
- WAIT: on `mem_rvalid`, register the extracted data, then go to RESP. `mem_rvalid` is ignored in every other state.
- RESP: `rsp_valid` = 1 for exactly one cycle, then return to IDLE.
- Lane rules, with off = `addr`[log2(`NB`)-1:0] and n = bytes(size):
  - `mem_be` = ((1<<n)-1) << off.
  - `mem_wdata` = the low n bytes of `wdata` replicated across all lanes.
  - Load data = `mem_rdata` >> (8·off). Keep the low 8n bits, then extend from bit 8n-1 per `req_unsigned`.
  - A full-width access (n = `NB`) is not extended.
- The error path never asserts `mem_valid`.

## Timing
- Reset values: state IDLE. `mem_valid`, `mem_we`, `mem_be`, `mem_addr`, `mem_wdata`, `rsp_valid`, `rsp_data` and `rsp_err` are all 0. `req_ready` is 0 while `reset` is high and 1 on the first edge after release.
- All outputs are registered or decoded from state only. There is no combinational path from `req_*` to `mem_*` or to `rsp_*`.
- Latency, with acceptance at edge T:
  - Error: `rsp_valid` in cycle T+1.
  - Store with `mem_ready` held high: `rsp_valid` at T+2.
  - Load with `mem_rvalid` one cycle after acceptance: `rsp_valid` at T+3.
- Each cycle that `mem_ready` is low adds one cycle of latency. Each cycle that `mem_rvalid` is absent in WAIT adds one cycle.
- Reset asserted in any state returns the FSM to IDLE immediately and drops `mem_valid`. Any late `mem_rvalid` is then discarded.
- `req_valid` arriving during RESP is not accepted until the following cycle, when the FSM is back in IDLE.

## Test plan
- Byte loads, `DATA_W`=32, addr 0x1003, `mem_rdata` 0x80FF_1234:
  - Signed: `mem_be` 4'b1000, `rsp_data` 0xFFFF_FF80.
  - Unsigned: `rsp_data` 0x0000_0080.
- Half store, addr 0x2002, `wdata` 0x0000_ABCD -> `mem_addr` 0x2000, `mem_be` 4'b1100, `mem_wdata` 0xABCD_ABCD, `rsp_valid` at T+2.
- Illegal accesses, each giving `rsp_err`=1 and `rsp_data`=0 at T+1 with `mem_valid` never high:
  - Word load at addr 0x1002.
  - size 11 with `DATA_W`=32.
- Backpressure: `mem_ready` low for 3 cycles -> `mem_valid`, `mem_addr` and `mem_be` stay stable and `req_ready` stays 0; `rsp_valid` arrives exactly 3 cycles later than the no-stall case.
- `DATA_W`=64, signed word load, addr 0x0104, `mem_rdata` 0x8765_4321_0000_0000 -> `mem_be` 8'hF0, `rsp_data` 0xFFFF_FFFF_8765_4321.
- Reset during WAIT, then `mem_rvalid` pulsed after reset release -> no `rsp_valid`, `req_ready`=1, and a subsequent load completes normally.
